rx_fsm: RTL and testbench
=========================

RX_FSM -- requirements
Module: rx_fsm

Interface
REQ-001 Parameter: CLKS_PER_BIT, 4, clock cycles per serial bit period; legal values are even numbers from 4 to 256.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: nrst  input  1  reset, asynchronous, active-low.
REQ-004 Port: rx_ctrl  input  1  receive enable; when low in IDLE, start edges are ignored.
REQ-005 Port: rx_din  input  1  serial line, idles high, asynchronous to clk.
REQ-006 Port: rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-007 Port: receive_ready  output  1  high only while in IDLE.
REQ-008 Port: rx_data  output  8  last accepted frame payload, MSB first on the wire.
REQ-009 Port: rx_valid  output  1  rx_data holds an unacknowledged good frame.
REQ-010 Port: success  output  1  one-cycle pulse per good frame.
REQ-011 Port: rx_error  output  1  sticky framing/parity error; cleared by rx_ack or reset.
REQ-012 Port: overrun  output  1  sticky; a good frame completed while rx_valid was high; cleared by rx_ack.

Function
REQ-013 rx_din SHALL pass through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-014 States: IDLE, START, DATA, PARITY (macro only), STOP, DONE.
REQ-015 IDLE -> START when rx_ctrl=1 and a synchronized 1->0 edge is seen.
REQ-016 START: wait CLKS_PER_BIT/2 cycles and sample; 0 -> DATA; 1 -> IDLE as a false start, with no flags set.
REQ-017 DATA: sample every CLKS_PER_BIT cycles, shifting left into an 8-bit register; after the 8th sample go to PARITY or STOP.
REQ-018 STOP: sample after CLKS_PER_BIT cycles; 1 with no parity error -> DONE; otherwise set rx_error and go to IDLE with rx_data unchanged.
REQ-019 DONE (one cycle): load rx_data, pulse success, set rx_valid, then go to IDLE; success is asserted 1 cycle after the stop-bit sample.
REQ-020 In DONE with rx_valid already 1 and no rx_ack in that cycle: set overrun and overwrite rx_data.
REQ-021 rx_ack and DONE in the same cycle: DONE wins; rx_valid stays 1 and overrun is not set.
REQ-022 rx_ctrl falling mid-frame SHALL NOT abort the frame; it gates only new starts.
REQ-023 The bit-period counter SHALL reload at each state entry and never wrap silently.

Reset
REQ-024 On nrst=0, asynchronously: state=IDLE, rx_data=8'h00, rx_valid=0, success=0, rx_error=0, overrun=0, synchronizer=1, counters=0; receive_ready=1.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first start is recognised at the first 1->0 edge after release.

Configuration
REQ-026 Macro RX_PARITY_EN defined: the frame carries an even-parity bit after D0, the PARITY state samples it, and a mismatch sets rx_error in STOP.
REQ-027 Macro RX_PARITY_EN undefined: no PARITY state or logic; frame = start + 8 data + stop.

Structure
REQ-028 Package rx_pkg SHALL hold the state enum type, DATA_BITS=8, and the IDLE_LEVEL=1 constant.
REQ-029 Sub-module rx_bit_timer (load, half/full period select, tick output) SHALL implement the bit-period counter.

Verification (CLKS_PER_BIT=4, parity off unless stated)
REQ-030 Frame 0,1,1,0,0,1,0,1,1,1 (start, data 8'hCB, stop) -> rx_data=8'hCB, success pulses once, rx_valid=1, rx_error=0.
REQ-031 rx_din low for 1 cycle then high -> returns to IDLE, no flags set, receive_ready=1 within CLKS_PER_BIT/2+3 cycles.
REQ-032 Frame 8'hA5 with stop bit 0 -> rx_error=1, rx_valid=0, rx_data unchanged.
REQ-033 Two good frames 8'h11 then 8'h22 with no rx_ack -> overrun=1, rx_data=8'h22; rx_ack clears rx_valid and overrun.
REQ-034 nrst pulsed low during data bit 4 -> all outputs reach reset values immediately; the next full frame 8'h3C is received correctly.
REQ-035 RX_PARITY_EN defined: 8'h07 with parity 1 -> good frame; the same frame with parity 0 -> rx_error=1.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg -- shared definitions for the serial receiver.
//   DATA_BITS  : payload width of one frame
//   IDLE_LEVEL : level of the serial line when no frame is in flight
//   rx_state_e : receiver FSM states; ST_PARITY exists only when
//                RX_PARITY_EN is defined
package rx_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer -- bit-period down-counter for the receiver.
//   clk, nrst : clock, asynchronous active-low reset (counter resets to 0)
//   load      : reload the counter this cycle
//   half      : with load, reload for half a bit period instead of a full one
//   tick      : counter has reached zero; the current period has elapsed
// The counter saturates at zero instead of wrapping, so a period that is
// not reloaded keeps reporting tick rather than silently restarting.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = half ? HALF_LOAD : FULL_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/rx_fsm.sv
// rx_fsm -- serial frame receiver (start, 8 data bits MSB first, stop).
// Optional feature: define RX_PARITY_EN to expect an even-parity bit after
// D0; a parity mismatch turns the frame into an error at the stop bit.
// Ports:
//   clk, nrst     : clock, asynchronous active-low reset
//   rx_ctrl       : receive enable; gates only the start of new frames
//   rx_din        : asynchronous serial line, idles high
//   rx_ack        : consumer acknowledge; clears rx_valid, rx_error, overrun
//   receive_ready : high while idle
//   rx_data       : payload of the last good frame
//   rx_valid      : rx_data holds an unacknowledged good frame
//   success       : one-cycle pulse per good frame (the cycle after the
//                   stop-bit sample); rx_data/rx_valid update at its end
//   rx_error      : sticky framing/parity error
//   overrun       : sticky; a good frame arrived while rx_valid was high
// Handshake: rx_valid rises with a new frame and stays high until a cycle
// with rx_ack=1. A frame completing in the same cycle as rx_ack keeps
// rx_valid high (the ack consumed the older frame) and does not overrun.
module rx_fsm
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_ctrl,
    input  logic       rx_din,
    input  logic       rx_ack,
    output logic       receive_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       success,
    output logic       rx_error,
    output logic       overrun
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e      state_q, state_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           prev_q, prev_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           success_q, success_d;
    logic           rx_error_q, rx_error_d;
    logic           overrun_q, overrun_d;
`ifdef RX_PARITY_EN
    logic           par_err_q, par_err_d;
`endif

    logic rx_s;
    logic fall;
    logic stop_ok;
    logic tmr_load;
    logic tmr_half;
    logic tmr_tick;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .nrst (nrst),
        .load (tmr_load),
        .half (tmr_half),
        .tick (tmr_tick)
    );

    // Two-flop synchronizer plus one history flop for 1->0 edge detection.
    assign sync1_d = rx_din;
    assign sync2_d = sync1_q;
    assign prev_d  = sync2_q;
    assign rx_s    = sync2_q;
    assign fall    = (prev_q == IDLE_LEVEL) && (rx_s != IDLE_LEVEL);

`ifdef RX_PARITY_EN
    assign stop_ok = (rx_s == IDLE_LEVEL) && !par_err_q;
`else
    assign stop_ok = (rx_s == IDLE_LEVEL);
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        success_d  = 1'b0;
        rx_error_d = rx_error_q;
        overrun_d  = overrun_q;
        tmr_load   = 1'b0;
        tmr_half   = 1'b0;
`ifdef RX_PARITY_EN
        par_err_d  = par_err_q;
`endif

        if (rx_ack) begin
            rx_valid_d = 1'b0;
            rx_error_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_ctrl && fall) begin
                    state_d  = ST_START;
                    tmr_load = 1'b1;
                    tmr_half = 1'b1;
                end
            end
            ST_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (tmr_tick) begin
                    if (rx_s != IDLE_LEVEL) begin
                        state_d   = ST_DATA;
                        tmr_load  = 1'b1;
                        bit_cnt_d = 3'd0;
`ifdef RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tmr_tick) begin
                    shift_d  = {shift_q[6:0], rx_s};
                    tmr_load = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
                // Even parity: data plus parity bit must hold an even count of ones.
                if (tmr_tick) begin
                    par_err_d = ^{shift_q, rx_s};
                    state_d   = ST_STOP;
                    tmr_load  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tmr_tick) begin
                    if (stop_ok) begin
                        state_d   = ST_DONE;
                        success_d = 1'b1;
                    end else begin
                        rx_error_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rx_ack) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= IDLE_LEVEL;
            sync2_q    <= IDLE_LEVEL;
            prev_q     <= IDLE_LEVEL;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            success_q  <= 1'b0;
            rx_error_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            success_q  <= success_d;
            rx_error_q <= rx_error_d;
            overrun_q  <= overrun_d;
`ifdef RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign receive_ready = (state_q == ST_IDLE);
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign success       = success_q;
    assign rx_error      = rx_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm -- directed bench for rx_fsm (CLKS_PER_BIT=4).
// Frames are driven bit by bit on negedges; a frame-level model predicts the
// registered outputs and the cycle of every success pulse, and a compare
// process checks the DUT against it every cycle. Define RX_PARITY_EN for
// both RTL and bench to cover the parity build.
module tb_rx_fsm;

  localparam int N = 4;
`ifdef RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int W = 32;
  localparam int KIND_GOOD = 0;
  localparam int KIND_ERR  = 1;
  localparam int KIND_NONE = 2;

  logic       clk;
  logic       nrst;
  logic       rx_ctrl;
  logic       rx_din;
  logic       rx_ack;
  logic       receive_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       success;
  logic       rx_error;
  logic       overrun;

  rx_fsm #(.CLKS_PER_BIT(N)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .rx_ctrl       (rx_ctrl),
    .rx_din        (rx_din),
    .rx_ack        (rx_ack),
    .receive_ready (receive_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .success       (success),
    .rx_error      (rx_error),
    .overrun       (overrun)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model and scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int success_cnt = 0;
  logic settled = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic m_valid = 1'b0;
  logic m_err = 1'b0;
  logic m_ovr = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: success timing against the predicted cycles, and all
  // registered outputs against the model while nothing is in flight.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (success === 1'b1) begin
        success_cnt++;
        if (exp_q.size() != 0) begin
          chk("success_cycle", cyc, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          chk("success_unexpected", {31'd0, success}, 32'd0);
        end
      end
      if (exp_q.size() != 0 && cyc > exp_q[0]) begin
        chk("success_missing", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (settled) begin
        chk("outputs", {20'd0, receive_ready, rx_valid, rx_error, overrun, rx_data},
            {20'd0, 1'b1, m_valid, m_err, m_ovr, m_data});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    rx_din = b;
    repeat (N) @(negedge clk);
  endtask

  // Called on a negedge. Success of a good frame is due on the cycle after
  // the stop sample: 2 sync flops + 1 edge detect + half a bit + the full
  // bit periods up to the stop bit.
  task automatic run_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                           input int kind, input logic ack_in_done);
    settled = 1'b0;
    if (kind == KIND_GOOD) exp_q.push_back(cyc + 3 + N / 2 + (NB - 1) * N);
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
`ifdef RX_PARITY_EN
    drive_bit((^d) ^ par_bad);
`else
    if (par_bad) $display("note: parity flag ignored in this build");
`endif
    drive_bit(stop);
    rx_din = 1'b1;
    if (ack_in_done) begin
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    if (kind == KIND_GOOD) begin
      if (m_valid && !ack_in_done) m_ovr = 1'b1;
      if (ack_in_done) begin
        m_ovr = 1'b0;
        m_err = 1'b0;
      end
      m_data = d;
      m_valid = 1'b1;
    end else if (kind == KIND_ERR) begin
      m_err = 1'b1;
    end
    settled = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_ack();
    settled = 1'b0;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    m_valid = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    settled = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    summary();
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int succ_before;
    logic [7:0] d;
    nrst = 1'b0;
    rx_ctrl = 1'b1;
    rx_din = 1'b1;
    rx_ack = 1'b0;
    #2;
    chk("reset_ready", {31'd0, receive_ready}, 32'd1);
    chk("reset_outputs", {20'd0, rx_valid, success, rx_error, overrun, rx_data}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    settled = 1'b1;

    // good frame 0xCB
    succ_before = success_cnt;
    run_frame(8'hCB, 1'b1, 1'b0, KIND_GOOD, 1'b0);
    chk("cb_data", {24'd0, rx_data}, 32'h0000_00CB);
    chk("cb_valid_err", {30'd0, rx_valid, rx_error}, 32'd2);
    chk("cb_one_pulse", success_cnt - succ_before, 32'd1);
    do_ack();
    chk("ack_valid", {31'd0, rx_valid}, 32'd0);

    // one-cycle glitch: false start, back to idle with no flags
    settled = 1'b0;
    rx_din = 1'b0;
    @(negedge clk);
    rx_din = 1'b1;
    repeat (N / 2 + 2) @(negedge clk);
    #2;
    chk("false_start_ready", {31'd0, receive_ready}, 32'd1);
    chk("false_start_flags", {29'd0, rx_valid, rx_error, overrun}, 32'd0);
    @(negedge clk);
    settled = 1'b1;
    repeat (2) @(negedge clk);

    // bad stop bit
    run_frame(8'hA5, 1'b0, 1'b0, KIND_ERR, 1'b0);
    chk("a5_err", {31'd0, rx_error}, 32'd1);
    chk("a5_valid", {31'd0, rx_valid}, 32'd0);
    chk("a5_data_kept", {24'd0, rx_data}, 32'h0000_00CB);
    do_ack();
    chk("ack_err", {31'd0, rx_error}, 32'd0);

    // starts ignored while disabled
    rx_ctrl = 1'b0;
    run_frame(8'h99, 1'b1, 1'b0, KIND_NONE, 1'b0);
    rx_ctrl = 1'b1;

    // overrun
    run_frame(8'h11, 1'b1, 1'b0, KIND_GOOD, 1'b0);
    run_frame(8'h22, 1'b1, 1'b0, KIND_GOOD, 1'b0);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_data", {24'd0, rx_data}, 32'h0000_0022);
    do_ack();
    chk("ovr_ack", {30'd0, rx_valid, overrun}, 32'd0);

    // ack in the same cycle as DONE: frame wins, no overrun
    run_frame(8'h33, 1'b1, 1'b0, KIND_GOOD, 1'b0);
    run_frame(8'h44, 1'b1, 1'b0, KIND_GOOD, 1'b1);
    chk("ackdone_state", {30'd0, rx_valid, overrun}, 32'd2);
    chk("ackdone_data", {24'd0, rx_data}, 32'h0000_0044);

    // reset in the middle of data bit 4
    settled = 1'b0;
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 7; i >= 4; i--) drive_bit(d[i]);
    rx_din = d[3];
    @(negedge clk);
    #3;
    nrst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, receive_ready}, 32'd1);
    chk("midrst_outputs", {20'd0, rx_valid, success, rx_error, overrun, rx_data}, 32'd0);
    m_data = 8'h00;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    rx_din = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    settled = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'h3C, 1'b1, 1'b0, KIND_GOOD, 1'b0);
    chk("post_rst_data", {24'd0, rx_data}, 32'h0000_003C);
    chk("post_rst_valid", {31'd0, rx_valid}, 32'd1);

`ifdef RX_PARITY_EN
    do_ack();
    run_frame(8'h07, 1'b1, 1'b0, KIND_GOOD, 1'b0);
    chk("par_good_data", {24'd0, rx_data}, 32'h0000_0007);
    chk("par_good_err", {31'd0, rx_error}, 32'd0);
    run_frame(8'h07, 1'b1, 1'b1, KIND_ERR, 1'b0);
    chk("par_bad_err", {31'd0, rx_error}, 32'd1);
    chk("par_total_pulses", success_cnt, 32'd7);
`else
    chk("total_pulses", success_cnt, 32'd6);
`endif

    repeat (4) @(negedge clk);
    chk("pending_success", exp_q.size(), 32'd0);
    summary();
    $finish;
  end

endmodule
